// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_pkg: state encoding and default widths shared by the duty ramp sequencer.
package pwm_ramp_pkg;
   typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, HOLD} state_e;
   localparam int DUTY_W_DEF = 10;
   localparam int DIV_W_DEF  = 32;
   localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/pwm_ramp_prescaler.sv
// pwm_ramp_prescaler: counts 0..div while running and flags the terminal count as a ramp tick.
module pwm_ramp_prescaler
   import pwm_ramp_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   assign tick = run && cnt_q == div;
   always_comb cnt_d = (clr || !run || tick) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: ramps a PWM duty toward a captured target, either fading once and holding
// or breathing continuously between the target and 0.
module pwm_duty_ramp
   import pwm_ramp_pkg::*;
#(
   parameter int DUTY_W = DUTY_W_DEF,
   parameter int DIV_W  = DIV_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              start,
   input  logic              mode,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic [DUTY_W-1:0] step_size,
   input  logic [DIV_W-1:0]  step_div,
   output logic [DUTY_W-1:0] duty_cycle,
   output logic              pwm_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  breath_cnt
);
   state_e              state_q, state_d;
   logic [DUTY_W-1:0]   duty_q, duty_d, tgt_q, tgt_d, step_q, step_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                mode_q, mode_d, done_q, done_d;
   logic [CNT_W-1:0]    breath_q, breath_d;
   logic                tick, run;
   logic [DUTY_W:0]     sum;
   logic signed [DUTY_W:0] diff;
   logic [DUTY_W-1:0]   floor_v, up_v, dn_v;

   assign run = state_q == RAMP_UP || state_q == RAMP_DOWN;

   pwm_ramp_prescaler #(.DIV_W(DIV_W)) u_presc (
      .clk (clk),
      .rst (rst),
      .clr (!en || start),
      .run (run),
      .div (div_q),
      .tick(tick)
   );

   // One extra bit on both sides so the step saturates instead of wrapping.
   assign sum     = {1'b0, duty_q} + {1'b0, step_q};
   assign diff    = $signed({1'b0, duty_q}) - $signed({1'b0, step_q});
   assign floor_v = mode_q ? '0 : tgt_q;
   assign up_v    = sum >= {1'b0, tgt_q} ? tgt_q : sum[DUTY_W-1:0];
   assign dn_v    = diff <= $signed({1'b0, floor_v}) ? floor_v : diff[DUTY_W-1:0];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         duty_q   <= '0;
         tgt_q    <= '0;
         step_q   <= '0;
         div_q    <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         breath_q <= '0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         tgt_q    <= tgt_d;
         step_q   <= step_d;
         div_q    <= div_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         breath_q <= breath_d;
      end

   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      tgt_d    = tgt_q;
      step_d   = step_q;
      div_d    = div_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      breath_d = breath_q;
      if (!en) begin
         state_d = IDLE;
         duty_d  = '0;
      end else if (start) begin
         tgt_d   = target_duty;
         step_d  = step_size | DUTY_W'(step_size == '0);
         div_d   = step_div;
         mode_d  = mode;
         state_d = target_duty > duty_q ? RAMP_UP : (target_duty < duty_q || mode) ? RAMP_DOWN : HOLD;
         done_d  = target_duty == duty_q && !mode;
      end else if (tick && state_q == RAMP_UP) begin
         duty_d = up_v;
         if (up_v == tgt_q) begin
            state_d = mode_q ? RAMP_DOWN : HOLD;
            done_d  = !mode_q;
         end
      end else if (tick && state_q == RAMP_DOWN) begin
         duty_d = dn_v;
         if (dn_v == floor_v) begin
            state_d  = !mode_q ? HOLD : tgt_q == '0 ? RAMP_DOWN : RAMP_UP;
            done_d   = !mode_q;
            breath_d = mode_q ? breath_q + 1'b1 : breath_q;
         end
      end
   end

   always_comb begin
      duty_cycle = duty_q;
      pwm_en     = state_q != IDLE;
      busy       = run;
      done       = done_q;
      breath_cnt = breath_q;
   end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed and random stimulus scored against a behavioural ramp model.
module tb_pwm_duty_ramp;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, start = 1'b0, mode = 1'b0;
  logic [9:0]  target_duty = '0, step_size = '0;
  logic [31:0] step_div = '0;
  logic [9:0]  duty_cycle;
  logic        pwm_en, busy, done;
  logic [15:0] breath_cnt;
  pwm_duty_ramp dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .mode       (mode),
    .target_duty(target_duty),
    .step_size  (step_size),
    .step_div   (step_div),
    .duty_cycle (duty_cycle),
    .pwm_en     (pwm_en),
    .busy       (busy),
    .done       (done),
    .breath_cnt (breath_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [9:0]  duty;
    logic        pen;
    logic        bsy;
    logic        dn;
    logic [15:0] br;
  } exp_t;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int          m_st = 0, m_duty = 0, m_tgt = 0, m_step = 0, m_div = 0, m_wait = 0;
  bit          m_mode = 1'b0;
  logic [15:0] m_br = '0;
  task automatic check(input bit ok, input string what);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s t=%0t duty=%0d pwm_en=%0b busy=%0b done=%0b breath=%0d",
               what, $time, duty_cycle, pwm_en, busy, done, breath_cnt);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_duty = 0; m_tgt = 0; m_step = 0; m_div = 0; m_wait = 0; m_mode = 1'b0; m_br = '0;
  endtask
  task automatic model_step();
    bit d = 1'b0;
    int fl;
    if (!en) begin
      m_st = 0; m_duty = 0;
    end else if (start) begin
      m_tgt = int'(target_duty); m_step = step_size == 0 ? 1 : int'(step_size);
      m_div = int'(step_div); m_mode = mode; m_wait = m_div;
      if (m_tgt > m_duty) m_st = 1;
      else if (m_tgt < m_duty || m_mode) m_st = 2;
      else begin m_st = 3; d = 1'b1; end
    end else if (m_st == 1 || m_st == 2) begin
      if (m_wait > 0) m_wait--;
      else begin
        m_wait = m_div;
        if (m_st == 1) begin
          m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
          if (m_duty == m_tgt) begin
            if (m_mode) m_st = 2;
            else begin m_st = 3; d = 1'b1; end
          end
        end else begin
          fl = m_mode ? 0 : m_tgt;
          m_duty = (m_duty - m_step < fl) ? fl : m_duty - m_step;
          if (m_duty == fl) begin
            if (!m_mode) begin m_st = 3; d = 1'b1; end
            else begin m_br++; m_st = (m_tgt == 0) ? 2 : 1; end
          end
        end
      end
    end
    sb.push_back('{duty: 10'(m_duty), pen: m_st != 0, bsy: m_st == 1 || m_st == 2, dn: d, br: m_br});
  endtask
  task automatic drive(input bit e, input bit s, input bit m, input logic [9:0] t,
                       input logic [9:0] sz, input logic [31:0] dv);
    @(negedge clk);
    en = e; start = s; mode = m; target_duty = t; step_size = sz; step_div = dv;
    model_step();
  endtask
  task automatic idle(input int n);
    repeat (n) drive(en, 1'b0, mode, target_duty, step_size, step_div);
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2;
    sb.push_back('0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  always @(posedge clk or posedge rst) begin : mon
    exp_t e, a;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = '{duty: duty_cycle, pen: pwm_en, bsy: busy, dn: done, br: breath_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got duty=%0d pwm_en=%0b busy=%0b done=%0b breath=%0d want duty=%0d pwm_en=%0b busy=%0b done=%0b breath=%0d",
                 $time, a.duty, a.pen, a.bsy, a.dn, a.br, e.duty, e.pen, e.bsy, e.dn, e.br);
      end
    end
  end
  initial begin
    #1;
    sb.push_back('0);
    rst = 1'b1;
    #1;
    check(duty_cycle === '0 && pwm_en === 1'b0 && busy === 1'b0 && done === 1'b0 && breath_cnt === '0,
          "reset state");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 10'd100, 10'd10, 32'd0);
    idle(12);
    drive(1, 1, 0, 10'd35, 10'd30, 32'd3);
    idle(4);
    check(duty_cycle === 10'd100 && busy === 1'b1, "duty held before wait expires");
    idle(1);
    check(duty_cycle === 10'd70 && busy === 1'b1, "first step after step_div wait");
    idle(11);
    drive(0, 0, 0, 10'd0, 10'd0, 32'd0);
    drive(1, 1, 1, 10'd1023, 10'd512, 32'd0);
    idle(12);
    drive(1, 1, 0, 10'd100, 10'd10, 32'd0);
    idle(4);
    drive(0, 0, 0, 10'd100, 10'd10, 32'd0);
    drive(0, 1, 0, 10'd100, 10'd10, 32'd0);
    idle(2);
    drive(1, 1, 0, 10'd60, 10'd7, 32'd1);
    idle(22);
    drive(1, 1, 0, 10'd60, 10'd9, 32'd0);
    idle(2);
    drive(1, 1, 0, 10'd65, 10'd0, 32'd0);
    idle(8);
    drive(1, 1, 1, 10'd0, 10'd5, 32'd0);
    idle(5);
    drive(1, 1, 1, 10'd200, 10'd50, 32'd1);
    idle(10);
    async_reset();
    idle(3);
    drive(1, 1, 1, 10'd90, 10'd40, 32'd0);
    idle(6);
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 14) == 0, 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 1023)),
            ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 600)),
            32'($urandom_range(0, 4)));
    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
